// File: rtl/latch_reg_load_arbiter.sv
// latch_reg_load_arbiter: round-robin arbiter sequencing setup/open/hold writes into a shared level-sensitive latch
module latch_reg_load_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 4,
    parameter int OPEN_CYCLES = 1,
    localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id,
    output logic [WIDTH-1:0]       lat_d,
    output logic                   lat_en
);
    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic             lat_en_q, lat_en_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [IDW-1:0]   grant_q, grant_d, last_q, last_d, pick;
    logic [3:0]       cnt_q, cnt_d;
    logic             found;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= N_REQ; i++)
            if (!found && req[(int'(last_q) + i) % N_REQ]) begin
                found = 1'b1;
                pick  = IDW'((int'(last_q) + i) % N_REQ);
            end
    end

    always_comb begin
        state_d = state_q;
        lat_d_d = lat_d_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:
                if (found) begin
                    state_d = SETUP;
                    lat_d_d = data_in[int'(pick)*WIDTH +: WIDTH];
                    grant_d = pick;
                    last_d  = pick;
                end
            SETUP: begin
                state_d = OPEN;
                cnt_d   = '0;
            end
            OPEN:
                if (cnt_q == 4'(OPEN_CYCLES - 1)) state_d = HOLD;
                else cnt_d = cnt_q + 4'd1;
            default: state_d = IDLE;
        endcase
        // enable and ack are decoded from the next state so both leave the block as flop outputs
        lat_en_d = (state_d == OPEN);
        ack_d    = '0;
        if (state_d == HOLD) ack_d[grant_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_d_q  <= '0;
            lat_en_q <= 1'b0;
            ack_q    <= '0;
            grant_q  <= '0;
            last_q   <= IDW'(N_REQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            ack_q    <= ack_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;
    assign lat_d    = lat_d_q;
    assign lat_en   = lat_en_q;
endmodule

// File: tb/tb_latch_reg_load_arbiter.sv
// tb_latch_reg_load_arbiter: directed and random checks of two arbiter instances (OPEN_CYCLES 1 and 3) against a write-timeline model
module tb_latch_reg_load_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data_in;
    logic [3:0]  ack_a, ack_b, lat_d_a, lat_d_b;
    logic [1:0]  gid_a, gid_b;
    logic        busy_a, busy_b, lat_en_a, lat_en_b;

    int passed = 0;
    int total  = 0;

    int pos[2], gnt[2], lst[2];
    logic [3:0] mlat[2];
    int oc[2] = '{1, 3};

    always #5 clk = ~clk;

    latch_reg_load_arbiter #(.N_REQ(4), .WIDTH(4), .OPEN_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack_a),
        .busy(busy_a), .grant_id(gid_a), .lat_d(lat_d_a), .lat_en(lat_en_a));

    latch_reg_load_arbiter #(.N_REQ(4), .WIDTH(4), .OPEN_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack_b),
        .busy(busy_b), .grant_id(gid_b), .lat_d(lat_d_b), .lat_en(lat_en_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    // pos counts cycles into a write: 1 setup, 2..1+oc open, 2+oc hold, 0 idle
    task automatic model_edge();
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                pos[u] = 0; gnt[u] = 0; lst[u] = 3; mlat[u] = 4'h0;
            end else if (pos[u] == 0) begin
                int p;
                p = rr_pick(lst[u], req);
                if (p >= 0) begin
                    pos[u] = 1; gnt[u] = p; lst[u] = p; mlat[u] = data_in[p*4 +: 4];
                end
            end else pos[u] = (pos[u] == 2 + oc[u]) ? 0 : pos[u] + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("a_busy",   busy_a,   pos[0] != 0);
        chk("a_lat_en", lat_en_a, pos[0] >= 2 && pos[0] <= 1 + oc[0]);
        chk("a_lat_d",  lat_d_a,  mlat[0]);
        chk("a_gid",    gid_a,    gnt[0]);
        chk("a_ack",    ack_a,    (pos[0] == 2 + oc[0]) ? (32'd1 << gnt[0]) : 32'd0);
        chk("b_busy",   busy_b,   pos[1] != 0);
        chk("b_lat_en", lat_en_b, pos[1] >= 2 && pos[1] <= 1 + oc[1]);
        chk("b_lat_d",  lat_d_b,  mlat[1]);
        chk("b_gid",    gid_b,    gnt[1]);
        chk("b_ack",    ack_b,    (pos[1] == 2 + oc[1]) ? (32'd1 << gnt[1]) : 32'd0);
    endtask

    initial begin
        int n, en_cnt, ack_cnt, prev;
        int ord[8], lat[8], cyc[8];
        rst_n = 1'b0; req = 4'($urandom); data_in = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_lat_en", lat_en_a, 0);
            chk("t1_lat_d", lat_d_a, 0);
            chk("t1_ack", ack_a, 0);
            chk("t1_busy", busy_a, 0);
            chk("t1_gid", gid_a, 0);
            req = 4'($urandom); data_in = 16'($urandom);
        end
        rst_n = 1'b1; req = 4'h0;
        step(); step();
        req = 4'b0100; data_in = 16'h0A00;
        step();
        chk("t2_setup_lat_d", lat_d_a, 4'hA);
        chk("t2_setup_lat_en", lat_en_a, 0);
        step();
        chk("t2_open_lat_en", lat_en_a, 1);
        step();
        chk("t2_hold_lat_en", lat_en_a, 0);
        chk("t2_hold_ack", ack_a, 4'b0100);
        req = 4'h0;
        step();
        chk("t2_busy", busy_a, 0);
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'hF; data_in = 16'h4321; n = 0;
        for (int t = 0; t < 30 && n < 4; t++) begin
            step();
            if (ack_a != 0) begin
                ord[n] = gid_a; lat[n] = lat_d_a; cyc[n] = t;
                n++;
                req = req & ~ack_a;
            end
        end
        chk("t3_count", n, 4);
        for (int k = 0; k < 4 && k < n; k++) begin
            chk("t3_order", ord[k], k);
            chk("t3_lat_d", lat[k], k + 1);
            if (k > 0) chk("t3_spacing", cyc[k] - cyc[k-1], 4);
        end
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'b1001; data_in = 16'($urandom); n = 0; prev = -1;
        for (int t = 0; t < 40 && n < 6; t++) begin
            step();
            if (ack_a != 0) begin
                if (n == 0) chk("t4_first", gid_a, 0);
                else chk("t4_alternate", gid_a, (prev == 0) ? 3 : 0);
                prev = gid_a; n++;
            end
        end
        chk("t4_count", n, 6);
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'b0010; data_in = 16'($urandom);
        step(); step();
        chk("t5_open", lat_en_a, 1);
        rst_n = 1'b0;
        step();
        chk("t5_lat_en", lat_en_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_lat_d", lat_d_a, 0);
        chk("t5_ack", ack_a, 0);
        rst_n = 1'b1; req = 4'h0;
        step();
        chk("t5_no_ack", ack_a, 0);
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'b0001; data_in = 16'h000C;
        step();
        chk("t6_setup_lat_d", lat_d_b, 4'hC);
        data_in = 16'h0003; req = 4'h0; en_cnt = 0; ack_cnt = 0;
        for (int t = 0; t < 6; t++) begin
            step();
            en_cnt += int'(lat_en_b);
            if (ack_b == 4'b0001) ack_cnt++;
            chk("t6_lat_d", lat_d_b, 4'hC);
        end
        chk("t6_en_cycles", en_cnt, 3);
        chk("t6_ack", ack_cnt, 1);
        for (int t = 0; t < 400; t++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            data_in = 16'($urandom);
            step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
